// File: rtl/iob_plic_claim_ctrl_if.sv
// IOb manager-side bus bundle for the PLIC claim/complete controller.
// master = requester (drives avalid/addr/wdata/wstrb), slave = subordinate.
interface iob_plic_claim_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  avalid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output avalid, addr, wdata, wstrb,
        input  rvalid, rdata, ready
    );

    modport slave (
        input  avalid, addr, wdata, wstrb,
        output rvalid, rdata, ready
    );
endinterface

// File: rtl/iob_plic_claim_ctrl.sv
// Hart-side PLIC claim/complete manager: claim ID over IOb, hand it to local
// service, then write it back. Optional claim timeout: IOB_PLIC_CLAIM_TIMEOUT_EN.
module iob_plic_claim_ctrl #(
    parameter int              ADDR_W         = 16,
    parameter int              DATA_W         = 32,
    parameter int              ID_W           = 8,
    parameter logic [ADDR_W-1:0] CLAIM_ADDR   = 16'h0204,
    parameter int              TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 cke_i,
    input  logic                 enable_i,
    input  logic                 meip_i,
    iob_plic_claim_ctrl_if.master iob,
    output logic                 irq_valid_o,
    output logic [ID_W-1:0]      irq_id_o,
    input  logic                 irq_done_i,
    output logic [7:0]           spurious_cnt_o,
    output logic                 busy_o
`ifdef IOB_PLIC_CLAIM_TIMEOUT_EN
    ,
    output logic                 err_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CLAIM_REQ,
        CLAIM_WAIT,
        SERVICE,
        CMPL_REQ
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [7:0]            spur_q, spur_d;
    logic                  avalid_q, avalid_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic                  irq_valid_q, irq_valid_d;
    logic [ID_W-1:0]       irq_id_q, irq_id_d;
    logic                  busy_q, busy_d;

    logic [ID_W-1:0]       rid;
    logic                  unused_rdata;

    assign rid          = iob.rdata[ID_W-1:0];
    assign unused_rdata = ^iob.rdata[DATA_W-1:ID_W];

`ifdef IOB_PLIC_CLAIM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]            tmo_q, tmo_d;
    logic                  err_q, err_d;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        spur_d  = spur_q;
`ifdef IOB_PLIC_CLAIM_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (meip_i && enable_i) state_d = CLAIM_REQ;
            end
            CLAIM_REQ: begin
                if (iob.ready) begin
                    state_d = CLAIM_WAIT;
`ifdef IOB_PLIC_CLAIM_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end
            end
            CLAIM_WAIT: begin
                if (iob.rvalid) begin
                    if (rid != '0) begin
                        id_d    = rid;
                        state_d = SERVICE;
                    end else begin
                        if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
                        state_d = IDLE;
                    end
                end
`ifdef IOB_PLIC_CLAIM_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            SERVICE: begin
                if (irq_done_i) state_d = CMPL_REQ;
            end
            CMPL_REQ: begin
                if (iob.ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        avalid_d    = (state_d == CLAIM_REQ) || (state_d == CMPL_REQ);
        addr_d      = avalid_d ? CLAIM_ADDR : '0;
        wdata_d     = (state_d == CMPL_REQ) ? DATA_W'(id_d) : '0;
        wstrb_d     = (state_d == CMPL_REQ) ? '1 : '0;
        irq_valid_d = (state_d == SERVICE);
        irq_id_d    = (state_d == SERVICE) ? id_d : '0;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            id_q        <= '0;
            spur_q      <= '0;
            avalid_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            busy_q      <= 1'b0;
        end else if (cke_i) begin
            state_q     <= state_d;
            id_q        <= id_d;
            spur_q      <= spur_d;
            avalid_q    <= avalid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            busy_q      <= busy_d;
        end
    end

`ifdef IOB_PLIC_CLAIM_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else if (cke_i) begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    assign iob.avalid     = avalid_q;
    assign iob.addr       = addr_q;
    assign iob.wdata      = wdata_q;
    assign iob.wstrb      = wstrb_q;
    assign irq_valid_o    = irq_valid_q;
    assign irq_id_o       = irq_id_q;
    assign spurious_cnt_o = spur_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_iob_plic_claim_ctrl.sv
// Directed bench for iob_plic_claim_ctrl: cycle table plus corner sequences.
// Timeout checks compile in when IOB_PLIC_CLAIM_TIMEOUT_EN is defined.
module tb_iob_plic_claim_ctrl;

    logic       clk = 1'b0;
    logic       arst_i, cke_i, enable_i, meip_i, irq_done_i;
    logic       irq_valid_o, busy_o;
    logic [7:0] irq_id_o, spurious_cnt_o;
`ifdef IOB_PLIC_CLAIM_TIMEOUT_EN
    logic       err_o;
`endif

    int errs = 0;
    int checks = 0;
    int acc_cnt = 0;
    int wr_cnt = 0;
    int iv_seen = 0;

    iob_plic_claim_ctrl_if #(.ADDR_W(16), .DATA_W(32)) iob_if ();

    iob_plic_claim_ctrl #(.TIMEOUT_CYCLES(10)) dut (
        .clk_i          (clk),
        .arst_i         (arst_i),
        .cke_i          (cke_i),
        .enable_i       (enable_i),
        .meip_i         (meip_i),
        .iob            (iob_if),
        .irq_valid_o    (irq_valid_o),
        .irq_id_o       (irq_id_o),
        .irq_done_i     (irq_done_i),
        .spurious_cnt_o (spurious_cnt_o),
        .busy_o         (busy_o)
`ifdef IOB_PLIC_CLAIM_TIMEOUT_EN
        ,
        .err_o          (err_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!arst_i && cke_i && iob_if.avalid && iob_if.ready) begin
            acc_cnt++;
            if (iob_if.wstrb != 4'h0) wr_cnt++;
        end
        if (irq_valid_o) iv_seen++;
    end

    typedef struct {
        logic        meip, en, rdy, rv;
        logic [31:0] rd;
        logic        done;
        logic        av;
        logic [15:0] ad;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        iv;
        logic [7:0]  id;
        logic        bz;
        logic [7:0]  sp;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mv(
        input logic meip, en, rdy, rv, input logic [31:0] rd, input logic done,
        input logic av, input logic [15:0] ad, input logic [31:0] wd,
        input logic [3:0] ws, input logic iv, input logic [7:0] id,
        input logic bz, input logic [7:0] sp);
        vec_t v;
        v.meip = meip; v.en = en; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.done = done; v.av = av; v.ad = ad; v.wd = wd; v.ws = ws;
        v.iv = iv; v.id = id; v.bz = bz; v.sp = sp;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        arst_i = 1'b1;
        step();
        arst_i = 1'b0;
    endtask

    task automatic run_claim(input logic [31:0] rd);
        meip_i = 1'b1;
        step();
        meip_i = 1'b0;
        iob_if.ready = 1'b1;
        step();
        iob_if.ready = 1'b0;
        iob_if.rvalid = 1'b1;
        iob_if.rdata = rd;
        step();
        iob_if.rvalid = 1'b0;
        iob_if.rdata = '0;
    endtask

    localparam logic [15:0] A = 16'h0204;

    initial begin
        int a0, w0, iv0;
        vt[0]  = mv(1,1,0,0,32'h0,0,        1,A,32'h0,4'h0,0,8'h00,1,8'd0);
        vt[1]  = mv(1,1,1,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,1,8'd0);
        vt[2]  = mv(0,1,0,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,1,8'd0);
        vt[3]  = mv(0,1,0,1,32'hABCD0005,0, 0,0,32'h0,4'h0,1,8'h05,1,8'd0);
        vt[4]  = mv(0,1,0,0,32'h0,0,        0,0,32'h0,4'h0,1,8'h05,1,8'd0);
        vt[5]  = mv(0,1,0,0,32'h0,0,        0,0,32'h0,4'h0,1,8'h05,1,8'd0);
        vt[6]  = mv(0,1,0,0,32'h0,1,        1,A,32'h5,4'hF,0,8'h00,1,8'd0);
        vt[7]  = mv(0,1,1,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,0,8'd0);
        vt[8]  = mv(0,1,0,0,32'h0,1,        0,0,32'h0,4'h0,0,8'h00,0,8'd0);
        vt[9]  = mv(1,1,0,0,32'h0,0,        1,A,32'h0,4'h0,0,8'h00,1,8'd0);
        vt[10] = mv(0,1,1,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,1,8'd0);
        vt[11] = mv(0,1,0,1,32'hFFFFFF00,0, 0,0,32'h0,4'h0,0,8'h00,0,8'd1);
        vt[12] = mv(0,1,0,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,0,8'd1);
        vt[13] = mv(1,0,0,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,0,8'd1);
        vt[14] = mv(1,0,0,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,0,8'd1);
        vt[15] = mv(1,1,0,0,32'h0,0,        1,A,32'h0,4'h0,0,8'h00,1,8'd1);
        vt[16] = mv(0,1,1,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,1,8'd1);
        vt[17] = mv(0,1,0,1,32'h000000FF,0, 0,0,32'h0,4'h0,1,8'hFF,1,8'd1);
        vt[18] = mv(0,1,0,0,32'h0,1,        1,A,32'hFF,4'hF,0,8'h00,1,8'd1);
        vt[19] = mv(1,1,1,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,0,8'd1);
        vt[20] = mv(1,1,0,0,32'h0,0,        1,A,32'h0,4'h0,0,8'h00,1,8'd1);
        vt[21] = mv(1,0,0,0,32'h0,0,        1,A,32'h0,4'h0,0,8'h00,1,8'd1);
        vt[22] = mv(0,0,1,0,32'h0,0,        0,0,32'h0,4'h0,0,8'h00,1,8'd1);
        vt[23] = mv(0,0,0,1,32'h00000011,0, 0,0,32'h0,4'h0,1,8'h11,1,8'd1);

        arst_i = 1'b1; cke_i = 1'b1; enable_i = 1'b1; meip_i = 1'b0;
        irq_done_i = 1'b0;
        iob_if.ready = 1'b0; iob_if.rvalid = 1'b0; iob_if.rdata = '0;
        step();
        step();
        arst_i = 1'b0;
        chk("reset_state",
            {iob_if.avalid, iob_if.addr, iob_if.wdata, iob_if.wstrb,
             irq_valid_o, irq_id_o, busy_o, spurious_cnt_o}, '0);

        for (int i = 0; i < 24; i++) begin
            meip_i = vt[i].meip; enable_i = vt[i].en;
            iob_if.ready = vt[i].rdy; iob_if.rvalid = vt[i].rv;
            iob_if.rdata = vt[i].rd; irq_done_i = vt[i].done;
            step();
            chk($sformatf("vec%0d", i),
                {iob_if.avalid, iob_if.addr, iob_if.wdata, iob_if.wstrb,
                 irq_valid_o, irq_id_o, busy_o, spurious_cnt_o},
                {vt[i].av, vt[i].ad, vt[i].wd, vt[i].ws,
                 vt[i].iv, vt[i].id, vt[i].bz, vt[i].sp});
        end
        meip_i = 0; enable_i = 1; iob_if.ready = 0; iob_if.rvalid = 0;
        iob_if.rdata = '0; irq_done_i = 0;

        // reset while in SERVICE: no completion write may follow
        w0 = wr_cnt;
        do_reset();
        chk("rst_in_service",
            {irq_valid_o, iob_if.avalid, spurious_cnt_o, busy_o}, '0);
        step(); step(); step();
        chk("rst_no_write", 128'(wr_cnt - w0), 128'(0));
        chk("rst_idle", {iob_if.avalid, busy_o}, '0);

        // ready back-pressure on claim and on completion
        meip_i = 1'b1;
        step();
        meip_i = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_claim_hold",
                {iob_if.avalid, iob_if.addr, iob_if.wdata, iob_if.wstrb},
                {1'b1, A, 32'h0, 4'h0});
        end
        iob_if.ready = 1'b1;
        step();
        iob_if.ready = 1'b0;
        chk("bp_claim_accept", {iob_if.avalid, 32'(acc_cnt - a0)}, {1'b0, 32'd1});
        iob_if.rvalid = 1'b1; iob_if.rdata = 32'h7;
        step();
        iob_if.rvalid = 1'b0; iob_if.rdata = '0;
        irq_done_i = 1'b1;
        step();
        irq_done_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_cmpl_hold",
                {iob_if.avalid, iob_if.addr, iob_if.wdata, iob_if.wstrb},
                {1'b1, A, 32'h7, 4'hF});
        end
        iob_if.ready = 1'b1;
        step();
        iob_if.ready = 1'b0;
        chk("bp_cmpl_accept", {busy_o, 32'(acc_cnt - a0)}, {1'b0, 32'd2});

        // spurious claims and counter saturation
        do_reset();
        w0 = wr_cnt; iv0 = iv_seen;
        for (int i = 0; i < 3; i++) run_claim(32'h0);
        chk("spur3_cnt", 128'(spurious_cnt_o), 128'(3));
        chk("spur3_no_irq_no_wr",
            {32'(iv_seen - iv0), 32'(wr_cnt - w0)}, '0);
        for (int i = 0; i < 252; i++) run_claim(32'h0);
        chk("spur255", 128'(spurious_cnt_o), 128'(255));
        for (int i = 0; i < 45; i++) run_claim(32'h0);
        chk("spur_sat", 128'(spurious_cnt_o), 128'(255));

        // cke freeze in CLAIM_REQ with ready high
        do_reset();
        meip_i = 1'b1;
        step();
        meip_i = 1'b0;
        a0 = acc_cnt;
        cke_i = 1'b0;
        iob_if.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("cke_freeze",
                {iob_if.avalid, iob_if.addr, busy_o, 32'(acc_cnt - a0)},
                {1'b1, A, 1'b1, 32'd0});
        end
        cke_i = 1'b1;
        step();
        iob_if.ready = 1'b0;
        chk("cke_resume", {iob_if.avalid, busy_o, 32'(acc_cnt - a0)},
            {1'b0, 1'b1, 32'd1});
        iob_if.rvalid = 1'b1; iob_if.rdata = 32'h9;
        step();
        iob_if.rvalid = 1'b0; iob_if.rdata = '0;
        chk("cke_service", {irq_valid_o, irq_id_o}, {1'b1, 8'h09});

`ifdef IOB_PLIC_CLAIM_TIMEOUT_EN
        do_reset();
        meip_i = 1'b1;
        step();
        meip_i = 1'b0;
        iob_if.ready = 1'b1;
        step();
        iob_if.ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("tmo_waiting", {err_o, busy_o}, {1'b0, 1'b1});
        end
        step();
        chk("tmo_fire", {err_o, busy_o}, {1'b1, 1'b0});
        step();
        chk("tmo_pulse_end", {err_o, busy_o}, '0);
        iob_if.rvalid = 1'b1; iob_if.rdata = 32'h5;
        step();
        iob_if.rvalid = 1'b0; iob_if.rdata = '0;
        chk("tmo_late_rvalid", {irq_valid_o, busy_o, spurious_cnt_o}, '0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
